// File: rtl/max_pool_2x2_if.sv
// Conv-result stream into the 2x2 max-pool stage and pooled stream out of it.
// The upstream/testbench side uses master, the pooling block uses slave.
interface max_pool_2x2_if #(
   parameter int DATA_W = 16
);
   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     frame_done;

   modport master (
      output in_data, in_valid,
      input  out_data, out_valid, frame_done
   );

   modport slave (
      input  in_data, in_valid,
      output out_data, out_valid, frame_done
   );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a row-major W x W conv map (W = SIZE-2).
// Odd columns fold pairs into a half-width line buffer; odd rows close the window.
module max_pool_2x2 #(
   parameter int SIZE   = 7,
   parameter int DATA_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   max_pool_2x2_if.slave  bus
);
   localparam int W    = SIZE - 2;
   localparam int HALF = W / 2;
   localparam int CW   = $clog2(W + 1);
   localparam int LB_N = (HALF > 0) ? HALF : 1;
   localparam int IW   = (LB_N > 1) ? $clog2(LB_N) : 1;

   logic [CW-1:0]            r_col;
   logic [CW-1:0]            r_row;
   logic signed [DATA_W-1:0] r_hold;
   logic signed [DATA_W-1:0] r_linebuf [LB_N];
   logic signed [DATA_W-1:0] r_out_data;
   logic                     r_out_valid;
   logic                     r_frame_done;

   logic                     w_col_last;
   logic                     w_row_last;
   logic                     w_col_pool;
   logic                     w_row_pool;
   logic [IW-1:0]            w_lb_idx;
   logic signed [DATA_W-1:0] w_lb_rd;
   logic signed [DATA_W-1:0] w_pair_max;
   logic signed [DATA_W-1:0] w_win_max;

   function automatic logic signed [DATA_W-1:0] smax(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   // Trailing odd row/column of an odd-width map fall outside every window.
   assign w_col_last = (r_col == CW'(W - 1));
   assign w_row_last = (r_row == CW'(W - 1));
   assign w_col_pool = (r_col < CW'(2 * HALF));
   assign w_row_pool = (r_row < CW'(2 * HALF));
   assign w_lb_idx   = IW'(r_col >> 1);
   assign w_lb_rd    = r_linebuf[w_lb_idx];
   assign w_pair_max = smax(r_hold, bus.in_data);
   assign w_win_max  = smax(w_lb_rd, w_pair_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_hold       <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < LB_N; i++) r_linebuf[i] <= '0;
      end else if (clr) begin
         r_col        <= '0;
         r_row        <= '0;
         r_hold       <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < LB_N; i++) r_linebuf[i] <= '0;
      end else begin
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         if (bus.in_valid) begin
            if (w_col_pool && w_row_pool) begin
               if (!r_col[0]) begin
                  r_hold <= bus.in_data;
               end else if (!r_row[0]) begin
                  r_linebuf[w_lb_idx] <= w_pair_max;
               end else begin
                  r_out_data  <= w_win_max;
                  r_out_valid <= 1'b1;
               end
            end
            if (w_col_last) begin
               r_col <= '0;
               if (w_row_last) begin
                  r_row        <= '0;
                  r_frame_done <= 1'b1;
               end else begin
                  r_row <= r_row + CW'(1);
               end
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
      end
   end

   assign bus.out_data   = r_out_data;
   assign bus.out_valid  = r_out_valid;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: W=5 instance (SIZE=7) and W=4 instance (SIZE=6).
module tb_max_pool_2x2;
   typedef struct {
      logic signed [15:0] d;
      int                 c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   max_pool_2x2_if #(.DATA_W(16)) b0 ();
   max_pool_2x2_if #(.DATA_W(16)) b1 ();

   max_pool_2x2 #(.SIZE(7), .DATA_W(16)) u_dut_w5 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b0.slave)
   );
   max_pool_2x2 #(.SIZE(6), .DATA_W(16)) u_dut_w4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b1.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t q0[$];
   exp_t q1[$];
   int   fd0[$];
   int   fd1[$];
   logic signed [15:0] frm [2][5][5];
   int   mr[2];
   int   mc[2];
   int   wm[2] = '{5, 4};

   task automatic check_eq(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // Reference: keep the whole frame, take the max of the four window samples.
   task automatic model_accept(input int k, input logic signed [15:0] d);
      int r, c, w;
      logic signed [15:0] m;
      exp_t e;
      r = mr[k];
      c = mc[k];
      w = wm[k];
      frm[k][r][c] = d;
      if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (w / 2)) && (c < 2 * (w / 2))) begin
         m = frm[k][r-1][c-1];
         if (frm[k][r-1][c] > m) m = frm[k][r-1][c];
         if (frm[k][r][c-1] > m) m = frm[k][r][c-1];
         if (frm[k][r][c]   > m) m = frm[k][r][c];
         e.d = m;
         e.c = cyc + 1;
         if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      if ((r == w - 1) && (c == w - 1)) begin
         if (k == 0) fd0.push_back(cyc + 1); else fd1.push_back(cyc + 1);
      end
      if (c == w - 1) begin
         mc[k] = 0;
         mr[k] = (r == w - 1) ? 0 : r + 1;
      end else begin
         mc[k] = c + 1;
      end
   endtask

   task automatic model_clear();
      mr[0] = 0; mc[0] = 0;
      mr[1] = 0; mc[1] = 0;
   endtask

   task automatic drive(input int k, input bit v, input logic signed [15:0] d);
      @(negedge clk);
      b0.in_valid = (k == 0) && v;
      b0.in_data  = d;
      b1.in_valid = (k == 1) && v;
      b1.in_data  = d;
      if (v) model_accept(k, d);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 1'b0, 16'sd0);
   endtask

   task automatic send_part(input int k, input int base, input int n, input bit gapped);
      for (int i = 0; i < n; i++) begin
         drive(k, 1'b1, 16'(base + i));
         if (gapped && ((i + 1) % 3 == 0)) idle(2);
         if (gapped && ((i + 1) % wm[k] == 0)) idle(2);
      end
   endtask

   task automatic drain(input string tag);
      idle(6);
      check_eq({tag, "_q0_left"}, q0.size(), 0);
      check_eq({tag, "_q1_left"}, q1.size(), 0);
      check_eq({tag, "_fd_left"}, fd0.size() + fd1.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (b0.out_valid) begin
         check_eq("w5_out_expected", q0.size() > 0, 1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check_eq("w5_out_data", b0.out_data, e.d);
            check_eq("w5_out_cycle", cyc, e.c);
         end
      end
      if (b1.out_valid) begin
         check_eq("w4_out_expected", q1.size() > 0, 1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check_eq("w4_out_data", b1.out_data, e.d);
            check_eq("w4_out_cycle", cyc, e.c);
         end
      end
      if (b0.frame_done) begin
         check_eq("w5_fd_expected", fd0.size() > 0, 1);
         if (fd0.size() > 0) check_eq("w5_fd_cycle", cyc, fd0.pop_front());
      end
      if (b1.frame_done) begin
         check_eq("w4_fd_expected", fd1.size() > 0, 1);
         if (fd1.size() > 0) check_eq("w4_fd_cycle", cyc, fd1.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout cycles=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      b0.in_valid = 1'b0; b0.in_data = '0;
      b1.in_valid = 1'b0; b1.in_data = '0;
      model_clear();
      #12;
      check_eq("rst_out_data", b0.out_data, 0);
      check_eq("rst_out_valid", b0.out_valid, 0);
      check_eq("rst_frame_done", b0.frame_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic frame 0..24
      send_part(0, 0, 25, 1'b0);
      drain("basic");

      // signed window, everything else at the most negative value
      for (int i = 0; i < 25; i++) begin
         logic signed [15:0] v;
         case (i)
            0:       v = -16'sd5;
            1:       v = -16'sd3;
            5:       v = -16'sd7;
            6:       v = -16'sd1;
            default: v = -16'sd32768;
         endcase
         drive(0, 1'b1, v);
      end
      drain("signed");

      send_part(0, 0, 25, 1'b1);
      drain("gapped");

      send_part(0, 0, 25, 1'b0);
      send_part(0, 100, 25, 1'b0);
      drain("b2b");

      // clr with a simultaneous sample: the sample must be dropped
      send_part(0, 0, 12, 1'b0);
      idle(1);
      @(negedge clk);
      clr = 1'b1;
      b0.in_valid = 1'b1;
      b0.in_data  = 16'sd999;
      model_clear();
      @(negedge clk);
      clr = 1'b0;
      b0.in_valid = 1'b0;
      check_eq("clr_out_data", b0.out_data, 0);
      check_eq("clr_out_valid", b0.out_valid, 0);
      send_part(0, 0, 25, 1'b0);
      drain("clr");

      // asynchronous reset mid-cycle
      send_part(0, 0, 12, 1'b0);
      idle(1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_out_data", b0.out_data, 0);
      check_eq("arst_out_valid", b0.out_valid, 0);
      check_eq("arst_frame_done", b0.frame_done, 0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      send_part(0, 0, 25, 1'b0);
      drain("arst");

      // even width: last window and frame_done share a cycle
      send_part(1, 0, 16, 1'b0);
      drain("even");
      check_eq("even_hold_data", b1.out_data, 15);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Consumer end of the convolution result stream. Receives row-major, ReLU6-clipped 16-bit conv results plus their valid strobe from the systolic-array conv stage.
- Performs 2x2, stride-2 max pooling over each (SIZE-2)x(SIZE-2) feature map.
- Emits one pooled value per completed window, plus a frame-done pulse for the downstream stage.

Parameters:
- SIZE, 7, conv input edge length; the pooled map is built from an input map of edge W = SIZE-2.
- DATA_W, 16, signed sample width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous frame abort; clears counters, line buffer and outputs next edge.
- in_data  input  DATA_W  signed conv result sample.
- in_valid  input  1  in_data is a valid sample this cycle.
- out_data  output  DATA_W  signed pooled maximum.
- out_valid  output  1  one-cycle pulse; out_data is valid.
- frame_done  output  1  one-cycle pulse after the last sample of a frame is accepted.

Behaviour:
- Reset (rst_n low, async): out_data=0, out_valid=0, frame_done=0, row/col counters=0, horizontal holding register=0, line buffer entries=0.
- clr=1 at a clock edge produces the same state as reset. clr has priority over in_valid in the same cycle.
- No backpressure: every cycle with in_valid=1 accepts one sample. in_valid may drop for any number of cycles mid-row or between rows; the upstream stage idles 2 cycles per row. Counters advance only on accepted samples.
- Counters: col runs 0..W-1, row runs 0..W-1. col wraps to 0 with row+1. After the sample at (W-1, W-1), both return to 0 and the next sample starts a new frame.
- Pooling rules per accepted sample (row r, col c):
  - c even, c < 2*(W/2): hold = in_data.
  - c odd, r even: linebuf[c/2] = max(hold, in_data).
  - c odd, r odd: out_data = max(linebuf[c/2], hold, in_data); out_valid = 1 on the following cycle.
  - Trailing odd column (c = W-1 with W odd) is ignored.
  - Trailing odd row (r = W-1 with W odd) is ignored.
- All comparisons are signed two's complement. No saturation is needed because a max cannot overflow.
- Line buffer depth is W/2 (floor) entries of DATA_W.
- Latency: registered output, 1 clock from the accepting edge of the window's 4th sample to out_valid high.
- Pooled outputs per frame: (W/2)^2, emitted row-major. Default is 4.
- frame_done goes high for exactly 1 cycle, one clock after the sample at (W-1, W-1) is accepted. It may coincide with out_valid when W is even.
- out_data holds its last value when out_valid=0.
- Back-to-back frames: a sample accepted in the same cycle that frame_done is high belongs to the new frame at (0,0). There is no bubble.
- Reset or clr mid-frame discards the partial frame; no out_valid is produced for incomplete windows.
- Spurious input when not in a frame does not exist: the block is always ready, and any accepted sample starts or continues a frame.

Test Plan:
- Basic frame, SIZE=7 (W=5): feed in_data=0..24 row-major, in_valid continuous. Required outputs in order: 6, 8, 16, 18. Each out_valid is 1 cycle after inputs 6, 8, 16 and 18 are accepted. frame_done is high 1 cycle after input 24. Samples in column 4 and row 4 never influence an output.
- Signed values: window {-5, -3, -7, -1} at (0,0)-(1,1), all other samples -32768. First output is -1 and the remaining three outputs are -32768.
- Gapped stream: same data as the basic frame, but in_valid low for 2 cycles after every 3rd sample and for 2 cycles at each row end. Output values are 6, 8, 16, 18, and out_valid count is exactly 4.
- Back-to-back frames: two frames with no idle cycles between them, the second frame being the basic-frame data +100. Outputs are 6, 8, 16, 18, 106, 108, 116, 118, and frame_done pulses twice.
- Abort and reset: assert clr for 1 cycle after 12 samples, then send a full frame of 0..24; outputs are 6, 8, 16, 18 with no stale window. Repeat using rst_n low asynchronously mid-cycle; all outputs read 0 immediately and the same result follows.
- Even width, SIZE=6 (W=4): feed 0..15. Outputs are 5, 7, 13, 15, and frame_done is in the same cycle as the out_valid for 15.
